ram_volts_reader: RTL and testbench

Read-side sequencer for the 310-entry voltage RAM. On a start request it walks RAM addresses 0 to Depth-1 and splits each 12-bit sample into two bytes, high byte first. It hands each byte to the UART transmitter with a start/done handshake and pulses `done_o` after the last byte. It sits between the voltage RAM (combinational read port) and the UART TX, and drives the RAM address bus while `busy_o` is high.

---
 rtl/ram_volts_reader_if.sv | 27 ++
 rtl/ram_volts_reader.sv | 113 +++++++++++
 tb/tb_ram_volts_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_volts_reader_if.sv
// ram_volts_reader_if
// Bundles the sequencer's bus and handshake signals: the dump request, the
// voltage RAM read port and the UART TX byte handshake.
//   master : the sequencer (drives addr_o, tx_start_o, tx_data_o, busy_o, done_o)
//   slave  : the surrounding system (drives start_i, doutram_i, tx_done_i)
interface ram_volts_reader_if #(
   parameter int Width = 12
);
   logic             start_i;
   logic [Width-1:0] doutram_i;
   logic             tx_done_i;
   logic [8:0]       addr_o;
   logic             tx_start_o;
   logic [7:0]       tx_data_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      input  start_i, doutram_i, tx_done_i,
      output addr_o, tx_start_o, tx_data_o, busy_o, done_o
   );

   modport slave (
      output start_i, doutram_i, tx_done_i,
      input  addr_o, tx_start_o, tx_data_o, busy_o, done_o
   );
endinterface

// File: rtl/ram_volts_reader.sv
// ram_volts_reader
// Walks the voltage RAM from address 0 to Depth-1 and streams every sample to
// the UART TX as two bytes, high byte first, then pulses done_o once.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : asynchronous reset, active high
//   bus    : master side of ram_volts_reader_if
//            start_i    dump request (only looked at in IDLE)
//            doutram_i  RAM read data for addr_o (combinational RAM)
//            tx_done_i  UART byte finished (only looked at in WAIT_HI/WAIT_LO)
//            addr_o     RAM address
//            tx_start_o one-cycle byte send request
//            tx_data_o  byte being sent
//            busy_o     dump in progress
//            done_o     one-cycle end-of-dump pulse
module ram_volts_reader #(
   parameter int Width = 12,
   parameter int Depth = 310
) (
   input logic                clk_i,
   input logic                rst_i,
   ram_volts_reader_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, DONE
   } state_t;

   localparam logic [8:0] LastAddr = 9'(Depth - 1);

   state_t           state_q, state_d;
   logic [8:0]       addr_q;
   logic [Width-1:0] sample_q;
   logic [7:0]       hi_byte;

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_i) state_d = LOAD;
         LOAD:    state_d = SEND_HI;
         SEND_HI: state_d = WAIT_HI;
         WAIT_HI: if (bus.tx_done_i) state_d = SEND_LO;
         SEND_LO: state_d = WAIT_LO;
         WAIT_LO: if (bus.tx_done_i) state_d = (addr_q == LastAddr) ? DONE : LOAD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address only moves on WAIT_LO->LOAD and DONE->IDLE, so the RAM output
   // has the whole LOAD cycle to settle before it is captured.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q   <= '0;
         sample_q <= '0;
      end else begin
         case (state_q)
            IDLE:    addr_q   <= '0;
            LOAD:    sample_q <= bus.doutram_i;
            WAIT_LO: if (bus.tx_done_i && addr_q != LastAddr) addr_q <= addr_q + 9'd1;
            DONE:    addr_q   <= '0;
            default: ;
         endcase
      end
   end

   // upper Width-8 bits, zero-extended to a byte
   always_comb begin
      hi_byte = '0;
      hi_byte[Width-9:0] = sample_q[Width-1:8];
   end

   // Moore outputs: decoded from state and sample only
   always_comb begin
      bus.tx_start_o = 1'b0;
      bus.tx_data_o  = 8'h00;
      bus.busy_o     = 1'b0;
      bus.done_o     = 1'b0;
      case (state_q)
         LOAD: bus.busy_o = 1'b1;
         SEND_HI: begin
            bus.busy_o     = 1'b1;
            bus.tx_start_o = 1'b1;
            bus.tx_data_o  = hi_byte;
         end
         WAIT_HI: begin
            bus.busy_o    = 1'b1;
            bus.tx_data_o = hi_byte;
         end
         SEND_LO: begin
            bus.busy_o     = 1'b1;
            bus.tx_start_o = 1'b1;
            bus.tx_data_o  = sample_q[7:0];
         end
         WAIT_LO: begin
            bus.busy_o    = 1'b1;
            bus.tx_data_o = sample_q[7:0];
         end
         DONE:    bus.done_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.addr_o = addr_q;

endmodule

// File: tb/tb_ram_volts_reader.sv
// tb_ram_volts_reader
// Two instances: a full 310-sample reader fed from a preloaded RAM model and a
// UART responder, and a one-sample reader driven cycle by cycle from a table.
module tb_ram_volts_reader;

   localparam int RspDly = 3;

   logic clk;
   logic rst;

   ram_volts_reader_if #(.Width(12)) bus  ();
   ram_volts_reader_if #(.Width(12)) bus1 ();

   ram_volts_reader #(.Width(12), .Depth(310)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.master)
   );

   ram_volts_reader #(.Width(12), .Depth(1)) dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus1.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models
   logic [11:0] ram [512];
   initial for (int i = 0; i < 512; i++) ram[i] = (i < 310) ? 12'(i) : 12'h000;
   assign bus.doutram_i  = ram[bus.addr_o];
   assign bus1.doutram_i = (bus1.addr_o == 9'd0) ? 12'hABC : 12'h000;

   // UART responder plus injected stray tx_done pulses
   logic rsp_en, done_rsp, done_inj;
   assign bus.tx_done_i = done_rsp | done_inj;

   initial begin
      done_rsp = 1'b0;
      @(negedge clk);
      forever begin
         if (rsp_en && bus.tx_start_o) begin
            repeat (RspDly) @(negedge clk);
            done_rsp = 1'b1;
            @(negedge clk);
            done_rsp = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   end

   // byte / done monitor
   logic [7:0] bytes [$];
   int         done_cnt;
   initial begin
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (bus.tx_start_o) bytes.push_back(bus.tx_data_o);
         if (bus.done_o) done_cnt++;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks, n_fail;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] outs0();
      return {12'd0, bus.tx_start_o, bus.tx_data_o, bus.busy_o, bus.done_o, bus.addr_o};
   endfunction

   function automatic logic [31:0] outs1();
      return {12'd0, bus1.tx_start_o, bus1.tx_data_o, bus1.busy_o, bus1.done_o, bus1.addr_o};
   endfunction

   task automatic check_stream(input string nm, input int b0);
      int n, mism;
      logic [7:0] e;
      n = bytes.size() - b0;
      mism = 0;
      check({nm, "_count"}, 32'(n), 32'd620);
      for (int i = 0; i < 620 && i < n; i++) begin
         e = (i % 2 == 0) ? 8'((i / 2) >> 8) : 8'((i / 2) & 255);
         if (bytes[b0 + i] !== e) mism++;
      end
      check({nm, "_bytes_wrong"}, 32'(mism), 32'd0);
   endtask

   // run the main reader until done_o, injecting the stray start/done pulses
   task automatic run_dump(input string nm, input bit inject);
      bit got, arm_start;
      got = 1'b0;
      arm_start = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         done_inj    = 1'b0;
         if (bus.done_o) begin
            got = 1'b1;
            break;
         end
         if (inject) begin
            if (arm_start) begin          // now in WAIT_HI of address 5
               bus.start_i = 1'b1;
               arm_start   = 1'b0;
            end
            if (bus.addr_o == 9'd5 && bus.tx_start_o && bus.tx_data_o == 8'h00) arm_start = 1'b1;
            // stray pulse coinciding with SEND_LO of address 7
            if (bus.addr_o == 9'd7 && bus.tx_start_o && bus.tx_data_o == 8'h07) done_inj = 1'b1;
         end
      end
      check({nm, "_done_seen"}, 32'(got), 32'd1);
   endtask

   typedef struct {
      logic        start;
      logic        txd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [27];

   task automatic row(input int i, input logic s, input logic d, input logic ts,
                      input logic [7:0] data, input logic busy, input logic dn);
      tbl[i].start = s;
      tbl[i].txd   = d;
      tbl[i].exp   = {12'd0, ts, data, busy, dn, 9'd0};
   endtask

   int b0, d0;
   bit found;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rsp_en   = 1'b0;
      done_inj = 1'b0;
      rst      = 1'b1;
      bus.start_i   = 1'b0;
      bus1.start_i  = 1'b0;
      bus1.tx_done_i = 1'b0;

      //   i  start txd  ts  data   busy done
      row( 0, 1, 0, 0, 8'h00, 0, 0);  // IDLE, start sampled
      row( 1, 0, 0, 0, 8'h00, 1, 0);  // LOAD
      row( 2, 0, 0, 1, 8'h0A, 1, 0);  // SEND_HI
      row( 3, 0, 1, 0, 8'h0A, 1, 0);  // WAIT_HI, done at once
      row( 4, 0, 0, 1, 8'hBC, 1, 0);  // SEND_LO
      row( 5, 0, 1, 0, 8'hBC, 1, 0);  // WAIT_LO
      row( 6, 0, 0, 0, 8'h00, 0, 1);  // DONE, 6 cycles after start edge
      row( 7, 0, 0, 0, 8'h00, 0, 0);  // IDLE
      row( 8, 0, 1, 0, 8'h00, 0, 0);  // stray done in IDLE
      row( 9, 0, 0, 0, 8'h00, 0, 0);  // still IDLE
      row(10, 1, 0, 0, 8'h00, 0, 0);
      row(11, 0, 0, 0, 8'h00, 1, 0);
      row(12, 0, 1, 1, 8'h0A, 1, 0);  // stray done in SEND_HI
      row(13, 0, 0, 0, 8'h0A, 1, 0);  // WAIT_HI keeps waiting
      row(14, 1, 1, 0, 8'h0A, 1, 0);  // accept, start ignored
      row(15, 0, 1, 1, 8'hBC, 1, 0);  // stray done in SEND_LO
      row(16, 0, 0, 0, 8'hBC, 1, 0);  // WAIT_LO keeps waiting
      row(17, 0, 1, 0, 8'hBC, 1, 0);
      row(18, 1, 0, 0, 8'h00, 0, 1);  // DONE, start held
      row(19, 1, 0, 0, 8'h00, 0, 0);  // IDLE re-triggers
      row(20, 0, 0, 0, 8'h00, 1, 0);
      row(21, 0, 0, 1, 8'h0A, 1, 0);
      row(22, 0, 1, 0, 8'h0A, 1, 0);
      row(23, 0, 0, 1, 8'hBC, 1, 0);
      row(24, 0, 1, 0, 8'hBC, 1, 0);
      row(25, 0, 0, 0, 8'h00, 0, 1);
      row(26, 0, 0, 0, 8'h00, 0, 0);

      repeat (2) @(negedge clk);
      check("reset_outs", outs0(), 32'd0);
      rst = 1'b0;

      // one-sample reader, cycle-exact table
      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         check($sformatf("vec%0d", i), outs1(), tbl[i].exp);
         bus1.start_i   = tbl[i].start;
         bus1.tx_done_i = tbl[i].txd;
      end
      @(negedge clk);
      bus1.start_i   = 1'b0;
      bus1.tx_done_i = 1'b0;

      // full dump with stray start and stray done pulses
      rsp_en = 1'b1;
      b0 = bytes.size();
      d0 = done_cnt;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      check("start_lat_busy", {31'd0, bus.busy_o}, 32'd1);
      check("start_lat_nostart", {31'd0, bus.tx_start_o}, 32'd0);
      @(negedge clk);
      check("start_lat_txstart", {31'd0, bus.tx_start_o}, 32'd1);
      run_dump("dump1", 1'b1);
      check("done_busy_low", {31'd0, bus.busy_o}, 32'd0);
      repeat (10) @(negedge clk);
      check_stream("dump1", b0);
      check("dump1_done_count", 32'(done_cnt - d0), 32'd1);
      check("dump1_addr_idle", {23'd0, bus.addr_o}, 32'd0);
      check("dump1_no_rerun", {31'd0, bus.busy_o}, 32'd0);

      // abort at address 100 with an asynchronous reset
      d0 = done_cnt;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (bus.addr_o == 9'd100) begin
            found = 1'b1;
            break;
         end
      end
      check("abort_reached_addr100", 32'(found), 32'd1);
      check("abort_busy_before", {31'd0, bus.busy_o}, 32'd1);
      #2 rst = 1'b1;
      #1 check("async_reset_outs", outs0(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_idle_outs", outs0(), 32'd0);

      // restart runs a complete dump from address 0
      b0 = bytes.size();
      d0 = done_cnt;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      run_dump("dump2", 1'b0);
      repeat (10) @(negedge clk);
      check_stream("dump2", b0);
      check("dump2_done_count", 32'(done_cnt - d0), 32'd1);
      check("dump2_addr_idle", {23'd0, bus.addr_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
